// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit direction counter encoding, its update rule,
// and the table entry layout used by the PC-indexed prediction table.
package bp_pkg;

    localparam int BPT_XLEN  = 32;
    localparam int BPT_TAG_W = BPT_XLEN;

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } ts_state;

    typedef struct packed {
        logic                 valid;
        logic [BPT_TAG_W-1:0] tag;
        logic [BPT_XLEN-1:0]  target;
        ts_state              ctr;
    } bpt_entry_t;

    function automatic ts_state ts_next(input ts_state s, input logic take);
        ts_state n;
        n = s;
        case (s)
            SN:      n = take ? WN : SN;
            WN:      n = take ? WT : SN;
            WT:      n = take ? ST : WN;
            ST:      n = take ? ST : WT;
            default: n = s;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Purpose: direct-mapped PC-indexed table of 2-bit direction counters plus branch targets.
// Latency: lookup registered to pred_* one cycle later; retire updates land at the same edge.
// Backpressure: lk_stall holds outputs, flush drops pred_valid; updates are never blocked.
module branch_pred_table
    import bp_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int N_ENTRIES = 16,
    localparam int IDX_BITS  = $clog2(N_ENTRIES)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            lk_valid,
    input  logic [XLEN-1:0] lk_pc,
    input  logic            lk_stall,
    input  logic            flush,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_take,
    input  logic [XLEN-1:0] upd_target,
    output logic            pred_valid,
    output logic            pred_take,
    output logic [XLEN-1:0] pred_target,
    output logic            pred_hit
);

    localparam int TAG_W = XLEN - IDX_BITS - 2;

    bpt_entry_t entries_q [N_ENTRIES];
    bpt_entry_t entries_d [N_ENTRIES];

    logic            pred_valid_q, pred_valid_d;
    logic            pred_take_q,  pred_take_d;
    logic            pred_hit_q,   pred_hit_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;

    logic [IDX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0]    lk_tag, upd_tag;
    bpt_entry_t          lk_ent, upd_ent;
    logic                lk_hit, lk_take, upd_hit;
    logic [1:0]          unused_upd_lsb;

    assign lk_idx         = lk_pc[IDX_BITS+1:2];
    assign lk_tag         = lk_pc[XLEN-1:IDX_BITS+2];
    assign upd_idx        = upd_pc[IDX_BITS+1:2];
    assign upd_tag        = upd_pc[XLEN-1:IDX_BITS+2];
    assign unused_upd_lsb = upd_pc[1:0];

    // Both ports read the pre-update table: a same-cycle lookup never sees the retiring write.
    assign lk_ent  = entries_q[lk_idx];
    assign upd_ent = entries_q[upd_idx];
    assign lk_hit  = lk_ent.valid && (lk_ent.tag == BPT_TAG_W'(lk_tag));
    assign lk_take = lk_hit && lk_ent.ctr[1];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == BPT_TAG_W'(upd_tag));

    always_comb begin
        entries_d = entries_q;
        if (upd_valid) begin
            if (upd_hit) begin
                entries_d[upd_idx].ctr = ts_next(upd_ent.ctr, upd_take);
                if (upd_take) begin
                    entries_d[upd_idx].target = BPT_XLEN'(upd_target);
                end
            end else if (upd_take) begin
                // Only taken branches earn a slot; a miss replaces whatever aliased there.
                entries_d[upd_idx].valid  = 1'b1;
                entries_d[upd_idx].tag    = BPT_TAG_W'(upd_tag);
                entries_d[upd_idx].target = BPT_XLEN'(upd_target);
                entries_d[upd_idx].ctr    = WT;
            end
        end
    end

    always_comb begin
        pred_valid_d  = pred_valid_q;
        pred_take_d   = pred_take_q;
        pred_hit_d    = pred_hit_q;
        pred_target_d = pred_target_q;
        if (flush) begin
            pred_valid_d = 1'b0;
        end else if (!lk_stall) begin
            pred_valid_d  = lk_valid;
            pred_take_d   = lk_take;
            pred_hit_d    = lk_hit;
            pred_target_d = lk_take ? XLEN'(lk_ent.target) : lk_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            pred_valid_q  <= 1'b0;
            pred_take_q   <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
        end else begin
            entries_q     <= entries_d;
            pred_valid_q  <= pred_valid_d;
            pred_take_q   <= pred_take_d;
            pred_hit_q    <= pred_hit_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_take   = pred_take_q;
    assign pred_hit    = pred_hit_q;
    assign pred_target = pred_target_q;

endmodule

// File: tb/tb_branch_pred_table.sv
// Self-checking bench for branch_pred_table: directed scenarios plus a random phase,
// with predictions from a reference model queued at drive time and compared after the edge.
module tb_branch_pred_table;

    logic        clock;
    logic        reset;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        lk_stall;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_take;
    logic [31:0] upd_target;
    logic        pred_valid;
    logic        pred_take;
    logic [31:0] pred_target;
    logic        pred_hit;

    branch_pred_table #(.XLEN(32), .N_ENTRIES(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .lk_valid   (lk_valid),
        .lk_pc      (lk_pc),
        .lk_stall   (lk_stall),
        .flush      (flush),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_take   (upd_take),
        .upd_target (upd_target),
        .pred_valid (pred_valid),
        .pred_take  (pred_take),
        .pred_target(pred_target),
        .pred_hit   (pred_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic        t;
        logic        h;
        logic [31:0] tg;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic        mo_valid, mo_take, mo_hit;
    logic [31:0] mo_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end
        mo_valid  = 1'b0;
        mo_take   = 1'b0;
        mo_hit    = 1'b0;
        mo_target = '0;
    endtask

    // One clock: drive at negedge, queue model prediction, update model, compare after posedge.
    task automatic cyc(input string tag, input logic lv, input logic [31:0] lpc,
                       input logic st, input logic fl, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        int          li, ui;
        logic        e_hit, e_take, u_hit;
        logic [31:0] e_tgt;
        exp_t        e, got;
        @(negedge clock);
        lk_valid = lv; lk_pc = lpc; lk_stall = st; flush = fl;
        upd_valid = uv; upd_pc = upc; upd_take = ut; upd_target = utg;

        li     = int'(lpc[5:2]);
        e_hit  = m_valid[li] && (m_tag[li] == lpc[31:6]);
        e_take = e_hit && (m_ctr[li] >= 2);
        e_tgt  = e_take ? m_tgt[li] : lpc + 32'd4;
        if (fl) begin
            mo_valid = 1'b0;
        end else if (!st) begin
            mo_valid  = lv;
            mo_hit    = e_hit;
            mo_take   = e_take;
            mo_target = e_tgt;
        end
        e.v = mo_valid; e.t = mo_take; e.h = mo_hit; e.tg = mo_target;
        sb.push_back(e);

        if (uv) begin
            ui    = int'(upc[5:2]);
            u_hit = m_valid[ui] && (m_tag[ui] == upc[31:6]);
            if (u_hit) begin
                if (ut) begin
                    m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                    m_tgt[ui] = utg;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                end
            end else if (ut) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = upc[31:6];
                m_tgt[ui]   = utg;
                m_ctr[ui]   = 2;
            end
        end

        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk({tag, ".valid"},  {31'd0, pred_valid}, {31'd0, got.v});
        chk({tag, ".take"},   {31'd0, pred_take},  {31'd0, got.t});
        chk({tag, ".hit"},    {31'd0, pred_hit},   {31'd0, got.h});
        chk({tag, ".target"}, pred_target,         got.tg);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc);
        cyc(tag, 1'b1, pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic update(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        cyc(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc, tk, tg);
    endtask

    initial begin
        reset = 1'b0;
        lk_valid = 1'b0; lk_pc = '0; lk_stall = 1'b0; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_take = 1'b0; upd_target = '0;
        model_clear();

        repeat (2) @(negedge clock);
        chk("rst.valid",  {31'd0, pred_valid}, 32'd0);
        chk("rst.take",   {31'd0, pred_take},  32'd0);
        chk("rst.hit",    {31'd0, pred_hit},   32'd0);
        chk("rst.target", pred_target,         32'd0);
        reset = 1'b1;

        // Cold lookup misses and falls through
        lookup("cold", 32'h100);
        chk("cold.tgt_const", pred_target, 32'h104);

        // Allocate as WT, then train down to SN
        update("alloc", 32'h100, 1'b1, 32'h200);
        lookup("after_alloc", 32'h100);
        chk("after_alloc.take_const", {31'd0, pred_take}, 32'd1);
        chk("after_alloc.tgt_const", pred_target, 32'h200);
        update("nt1", 32'h100, 1'b0, 32'h0);
        update("nt2", 32'h100, 1'b0, 32'h0);
        lookup("at_sn", 32'h100);
        chk("at_sn.tgt_const", pred_target, 32'h104);

        // Saturate to ST, then step back down
        for (int i = 0; i < 4; i++) update("sat_up", 32'h100, 1'b1, 32'h200);
        update("st_nt1", 32'h100, 1'b0, 32'h0);
        lookup("at_wt", 32'h100);
        chk("at_wt.take_const", {31'd0, pred_take}, 32'd1);
        update("st_nt2", 32'h100, 1'b0, 32'h0);
        lookup("at_wn", 32'h100);
        chk("at_wn.take_const", {31'd0, pred_take}, 32'd0);

        // Same-cycle lookup and update: lookup sees the pre-update WN
        cyc("rbw", 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h220);
        chk("rbw.take_const", {31'd0, pred_take}, 32'd0);
        lookup("rbw_next", 32'h100);
        chk("rbw_next.take_const", {31'd0, pred_take}, 32'd1);
        chk("rbw_next.tgt_const", pred_target, 32'h220);

        // Aliasing: 0x140 shares the index of 0x100 with a different tag
        update("alias_alloc", 32'h140, 1'b1, 32'h300);
        lookup("alias_old", 32'h100);
        chk("alias_old.hit_const", {31'd0, pred_hit}, 32'd0);
        lookup("alias_new", 32'h140);
        chk("alias_new.tgt_const", pred_target, 32'h300);

        // Stall holds outputs while lk_pc moves; flush during stall drops valid
        lookup("pre_stall", 32'h140);
        cyc("stall0", 1'b1, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("stall1", 1'b1, 32'h1c4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc("stall2", 1'b0, 32'h008, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall2.tgt_const", pred_target, 32'h300);
        cyc("flush_in_stall", 1'b1, 32'h180, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("flush.valid_const", {31'd0, pred_valid}, 32'd0);
        lookup("post_flush", 32'h144);
        cyc("idle", 1'b0, 32'hffff_fffc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap.tgt_const", pred_target, 32'h0);

        // Asynchronous reset between edges
        lookup("pre_areset", 32'h140);
        #2;
        reset = 1'b0;
        #1;
        chk("areset.valid",  {31'd0, pred_valid}, 32'd0);
        chk("areset.take",   {31'd0, pred_take},  32'd0);
        chk("areset.hit",    {31'd0, pred_hit},   32'd0);
        chk("areset.target", pred_target,         32'd0);
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        lookup("post_areset", 32'h140);
        chk("post_areset.tgt_const", pred_target, 32'h144);

        // Random mix over a small set of aliasing and distinct PCs
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pcs [6];
            logic [31:0] rl, ru;
            pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h104;
            pcs[3] = 32'h1180; pcs[4] = 32'h23c; pcs[5] = 32'h102;
            rl = pcs[$urandom_range(0, 5)];
            ru = pcs[$urandom_range(0, 5)];
            cyc("rnd", 1'($urandom_range(0, 3) != 0), rl,
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), ru, 1'($urandom_range(0, 2) != 0),
                {$urandom_range(0, 32'h3fff), 2'b00});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
